// File: rtl/mux_n_to_1_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_n_to_1_reg_if : handshake/data bundle for the registered N-to-1 mux     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mux_n_to_1_reg_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_IN*WIDTH-1:0] din;
    logic [SEL_W-1:0]      sel;
    logic                  scan_en;
    logic [N_IN-1:0]       chan_en;
    logic [N_IN-1:0]       inv_mask;
    logic [WIDTH-1:0]      dout;
    logic [SEL_W-1:0]      dout_ch;
    logic                  sel_err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_valid, din, sel, scan_en, chan_en, inv_mask, out_ready,
        input  in_ready, dout, dout_ch, sel_err, out_valid
    );

    modport slave (
        input  in_valid, din, sel, scan_en, chan_en, inv_mask, out_ready,
        output in_ready, dout, dout_ch, sel_err, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_n_to_1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_n_to_1_reg : registered N-to-1 word mux, per-channel invert/enable,     |
// | fixed-select or round-robin scan, valid/ready in and out. Rev 1.0           |
// +----------------------------------------------------------------------------+
module mux_n_to_1_reg #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_n_to_1_reg_if.slave bus
);
    localparam int               c_NPOW = 1 << SEL_W;
    localparam logic [SEL_W:0]   c_N_IN = (SEL_W+1)'(N_IN);
    localparam logic [SEL_W-1:0] c_LAST = SEL_W'(N_IN - 1);

    logic [WIDTH-1:0] r_dout;
    logic [SEL_W-1:0] r_dout_ch;
    logic             r_sel_err;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_scan_ptr;

    logic             w_in_ready;
    logic             w_accept;
    logic [c_NPOW-1:0] w_en_ext;
    logic [c_NPOW-1:0] w_inv_ext;
    logic [WIDTH-1:0] w_words [c_NPOW];
    logic             w_scan_found;
    logic [SEL_W-1:0] w_scan_ch;
    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_ch;
    logic [SEL_W-1:0] w_ch_out;
    logic             w_ok;
    logic [WIDTH-1:0] w_dout;
    logic [SEL_W-1:0] w_ptr_next;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.dout      = r_dout;
    assign bus.dout_ch   = r_dout_ch;
    assign bus.sel_err   = r_sel_err;
    assign bus.out_valid = r_out_valid;

    // Pad channel vectors to the full select range so out-of-range selects read as disabled.
    always_comb begin
        w_en_ext            = '0;
        w_inv_ext           = '0;
        w_en_ext[N_IN-1:0]  = bus.chan_en;
        w_inv_ext[N_IN-1:0] = bus.inv_mask;
        for (int i = 0; i < c_NPOW; i++) begin
            w_words[i] = '0;
        end
        for (int i = 0; i < N_IN; i++) begin
            w_words[i] = bus.din[i*WIDTH +: WIDTH];
        end
    end

    // First enabled channel at or after the scan pointer, wrapping modulo N_IN.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_ch    = r_scan_ptr;
        w_sum        = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_sum = {1'b0, r_scan_ptr} + (SEL_W+1)'(k);
            if (w_sum >= c_N_IN) begin
                w_sum = w_sum - c_N_IN;
            end
            if (!w_scan_found && w_en_ext[w_sum[SEL_W-1:0]]) begin
                w_scan_found = 1'b1;
                w_scan_ch    = w_sum[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        if (bus.scan_en) begin
            w_ch     = w_scan_ch;
            w_ok     = w_scan_found;
            w_ch_out = w_scan_found ? w_scan_ch : r_scan_ptr;
        end else begin
            w_ch     = bus.sel;
            w_ok     = w_en_ext[bus.sel];
            w_ch_out = bus.sel;
        end
        w_dout     = w_ok ? (w_words[w_ch] ^ {WIDTH{w_inv_ext[w_ch]}}) : '0;
        w_ptr_next = (w_scan_ch == c_LAST) ? '0 : w_scan_ch + SEL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_dout_ch   <= '0;
            r_sel_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_scan_ptr  <= '0;
        end else if (w_accept) begin
            r_dout      <= w_dout;
            r_dout_ch   <= w_ch_out;
            r_sel_err   <= !w_ok;
            r_out_valid <= 1'b1;
            if (bus.scan_en && w_scan_found) begin
                r_scan_ptr <= w_ptr_next;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mux_n_to_1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_n_to_1_reg : directed vector table plus hand-written corner cases    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mux_n_to_1_reg;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_n_to_1_reg_if #(.WIDTH(8), .N_IN(4)) b4 ();
    mux_n_to_1_reg_if #(.WIDTH(8), .N_IN(5)) b5 ();

    mux_n_to_1_reg #(.WIDTH(8), .N_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_n_to_1_reg #(.WIDTH(8), .N_IN(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    typedef struct {
        logic        scan;
        logic [1:0]  sel;
        logic [3:0]  en;
        logic [3:0]  inv;
        logic [31:0] din;
        logic [7:0]  e_dout;
        logic [1:0]  e_ch;
        logic        e_err;
    } vec_t;

    localparam int NV = 18;
    localparam logic [31:0] D0 = 32'h4433_2211;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic scan, input logic [1:0] sel, input logic [3:0] en,
                          input logic [3:0] inv, input logic [31:0] din);
        b4.scan_en  = scan;
        b4.sel      = sel;
        b4.chan_en  = en;
        b4.inv_mask = inv;
        b4.din      = din;
    endtask

    task automatic drive5(input logic scan, input logic [2:0] sel, input logic [4:0] en);
        b5.scan_en  = scan;
        b5.sel      = sel;
        b5.chan_en  = en;
        b5.inv_mask = 5'b0;
        b5.din      = 40'h55_4433_2211;
        b5.in_valid = 1'b1;
        b5.out_ready = 1'b1;
    endtask

    initial begin
        // Fixed-mode walk, disabled channel, scan sequence, empty scan, mode switch.
        tbl[0]  = '{1'b0, 2'd0, 4'hF, 4'b0101, D0, 8'hEE, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd1, 4'hF, 4'b0101, D0, 8'h22, 2'd1, 1'b0};
        tbl[2]  = '{1'b0, 2'd2, 4'hF, 4'b0101, D0, 8'hCC, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'd3, 4'hF, 4'b0101, D0, 8'h44, 2'd3, 1'b0};
        tbl[4]  = '{1'b0, 2'd2, 4'hB, 4'b0101, D0, 8'h00, 2'd2, 1'b1};
        tbl[5]  = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h11, 2'd0, 1'b0};
        tbl[6]  = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h22, 2'd1, 1'b0};
        tbl[7]  = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h44, 2'd3, 1'b0};
        tbl[8]  = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h11, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h22, 2'd1, 1'b0};
        tbl[10] = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h44, 2'd3, 1'b0};
        tbl[11] = '{1'b1, 2'd2, 4'hB, 4'b0000, D0, 8'h11, 2'd0, 1'b0};
        tbl[12] = '{1'b1, 2'd3, 4'h0, 4'b0000, D0, 8'h00, 2'd1, 1'b1};
        tbl[13] = '{1'b1, 2'd3, 4'hF, 4'b0000, D0, 8'h22, 2'd1, 1'b0};
        tbl[14] = '{1'b1, 2'd3, 4'h2, 4'b0000, D0, 8'h22, 2'd1, 1'b0};
        tbl[15] = '{1'b0, 2'd3, 4'hF, 4'b0000, D0, 8'h44, 2'd3, 1'b0};
        tbl[16] = '{1'b0, 2'd3, 4'hF, 4'b0000, 32'h8877_6655, 8'h88, 2'd3, 1'b0};
        tbl[17] = '{1'b1, 2'd0, 4'hF, 4'b0100, D0, 8'hCC, 2'd2, 1'b0};

        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        drive4(1'b0, 2'd0, 4'h0, 4'h0, 32'h0);
        b5.in_valid = 1'b0;
        b5.out_ready = 1'b1;
        b5.scan_en = 1'b0;
        b5.sel = 3'd0;
        b5.chan_en = 5'h0;
        b5.inv_mask = 5'h0;
        b5.din = 40'h0;

        tick();
        tick();
        chk("rst_dout", b4.dout, 8'h00);
        chk("rst_ch", b4.dout_ch, 2'd0);
        chk("rst_err", b4.sel_err, 1'b0);
        chk("rst_valid", b4.out_valid, 1'b0);
        chk("rst_ready", b4.in_ready, 1'b1);
        chk("rst_valid5", b5.out_valid, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive4(tbl[i].scan, tbl[i].sel, tbl[i].en, tbl[i].inv, tbl[i].din);
            b4.in_valid  = 1'b1;
            b4.out_ready = 1'b1;
            tick();
            chk($sformatf("v%0d_dout", i), b4.dout, tbl[i].e_dout);
            chk($sformatf("v%0d_ch", i), b4.dout_ch, tbl[i].e_ch);
            chk($sformatf("v%0d_err", i), b4.sel_err, tbl[i].e_err);
            chk($sformatf("v%0d_valid", i), b4.out_valid, 1'b1);
        end

        // Backpressure: held word must survive changing inputs.
        drive4(1'b0, 2'd1, 4'hF, 4'b0101, D0);
        tick();
        chk("bp_load", b4.dout, 8'h22);
        b4.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive4(1'b0, 2'd3, 4'hF, 4'b0101, 32'h0101_0101 * (k + 1));
            #1;
            chk($sformatf("bp%0d_ready", k), b4.in_ready, 1'b0);
            tick();
            chk($sformatf("bp%0d_dout", k), b4.dout, 8'h22);
            chk($sformatf("bp%0d_ch", k), b4.dout_ch, 2'd1);
            chk($sformatf("bp%0d_valid", k), b4.out_valid, 1'b1);
        end
        drive4(1'b0, 2'd2, 4'hF, 4'b0101, 32'hA4A3_A2A1);
        b4.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", b4.in_ready, 1'b1);
        tick();
        chk("bp_next_dout", b4.dout, 8'h5C);
        chk("bp_next_ch", b4.dout_ch, 2'd2);
        chk("bp_next_valid", b4.out_valid, 1'b1);
        b4.in_valid = 1'b0;
        tick();
        chk("drain_valid", b4.out_valid, 1'b0);
        chk("drain_hold", b4.dout, 8'h5C);
        b4.out_ready = 1'b0;
        tick();
        chk("idle_valid", b4.out_valid, 1'b0);
        chk("idle_ready", b4.in_ready, 1'b1);

        // Reset while a word is stalled and scan_ptr is 2.
        drive4(1'b1, 2'd0, 4'h2, 4'h0, D0);
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b1;
        tick();
        chk("pre_rst_ch", b4.dout_ch, 2'd1);
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", b4.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", b4.dout, 8'h00);
        chk("mid_rst_valid", b4.out_valid, 1'b0);
        chk("mid_rst_ready", b4.in_ready, 1'b1);
        chk("mid_rst_ch", b4.dout_ch, 2'd0);
        tick();
        rst_n = 1'b1;
        drive4(1'b1, 2'd0, 4'hF, 4'h0, D0);
        b4.in_valid  = 1'b1;
        b4.out_ready = 1'b1;
        tick();
        chk("post_rst_ch", b4.dout_ch, 2'd0);
        chk("post_rst_dout", b4.dout, 8'h11);
        chk("post_rst_valid", b4.out_valid, 1'b1);
        b4.in_valid = 1'b0;

        // Five-channel instance: out-of-range selects and scan wrap at N_IN.
        drive5(1'b0, 3'd4, 5'h1F);
        tick();
        chk("n5_sel4_dout", b5.dout, 8'h55);
        chk("n5_sel4_err", b5.sel_err, 1'b0);
        drive5(1'b0, 3'd6, 5'h1F);
        tick();
        chk("n5_sel6_dout", b5.dout, 8'h00);
        chk("n5_sel6_err", b5.sel_err, 1'b1);
        chk("n5_sel6_ch", b5.dout_ch, 3'd6);
        drive5(1'b0, 3'd5, 5'h1F);
        tick();
        chk("n5_sel5_err", b5.sel_err, 1'b1);
        chk("n5_sel5_ch", b5.dout_ch, 3'd5);
        drive5(1'b1, 3'd0, 5'b10000);
        tick();
        chk("n5_scan_c4", b5.dout_ch, 3'd4);
        chk("n5_scan_c4_dout", b5.dout, 8'h55);
        drive5(1'b1, 3'd0, 5'b00011);
        tick();
        chk("n5_scan_wrap_ch", b5.dout_ch, 3'd0);
        chk("n5_scan_wrap_dout", b5.dout, 8'h11);
        tick();
        chk("n5_scan_next_ch", b5.dout_ch, 3'd1);
        chk("n5_scan_next_err", b5.sel_err, 1'b0);
        b5.in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mux_n_to_1_reg.md
# mux_n_to_1_reg

Parametrised, registered N-to-1 word multiplexer with per-channel inversion, channel enables and an optional round-robin scan mode. Input and output each use a valid/ready handshake, and the block provides one output register stage. It is the clocked, multi-bit generalisation of the team's combinational select/invert muxes. It sits between parallel data sources and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 8, bits per channel word (≥1)
- N_IN, 4, number of input channels (≥2)
- SEL_W, $clog2(N_IN), select/channel-index width (derived; do not override)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  source presents a transfer request
- in_ready  out  1  block can accept a request this cycle
- din  in  N_IN*WIDTH  channel i at din[i*WIDTH +: WIDTH]
- sel  in  SEL_W  channel select, used when scan_en=0
- scan_en  in  1  1 = round-robin scan mode; sel ignored
- chan_en  in  N_IN  per-channel enable
- inv_mask  in  N_IN  1 = output bitwise inverse of that channel
- dout  out  WIDTH  registered output word
- dout_ch  out  SEL_W  index of the channel that produced dout
- sel_err  out  1  dout was forced to zero because of an invalid selection
- out_valid  out  1  dout, dout_ch and sel_err are valid
- out_ready  in  1  consumer accepts the output

## Operation
- Accept: a transfer is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput.
- Fixed mode (scan_en=0) at acceptance:
  - Channel c = sel.
  - If c < N_IN and chan_en[c]=1: dout = inv_mask[c] ? ~din[c] : din[c], sel_err=0.
  - If c ≥ N_IN or chan_en[c]=0: dout = 0, sel_err=1.
  - In all fixed-mode cases, dout_ch = sel.
- Scan mode (scan_en=1): an internal pointer scan_ptr (SEL_W bits) is used.
  - At acceptance, search for the first enabled channel starting at scan_ptr, ascending, wrapping N_IN-1 → 0.
  - If found at c: dout as in fixed mode for channel c, dout_ch=c, sel_err=0. Then scan_ptr ← (c+1) mod N_IN.
  - If no channel is enabled: dout=0, dout_ch=scan_ptr, sel_err=1, and scan_ptr is unchanged.
- scan_ptr updates only on accepted transfers in scan mode. It holds its value across fixed mode. Toggling scan_en takes effect at the next acceptance.
- Sampling: din, sel, chan_en and inv_mask are sampled only at acceptance. Output fields are stable while out_valid && !out_ready.
- Output register update, on each rising edge:
  - Acceptance: load new dout, dout_ch and sel_err, and set out_valid=1.
  - Else, if out_ready: out_valid=0, with dout, dout_ch and sel_err held.
  - Else: hold all outputs.
- Reset (asynchronous): dout=0, dout_ch=0, sel_err=0, out_valid=0, scan_ptr=0. in_ready=1 while in reset. A pending output is discarded.

## Timing
- Latency: acceptance at edge k gives out_valid=1 with data after edge k (visible in cycle k+1).
- Throughput: one word per cycle when out_ready is held at 1.
- Backpressure with out_valid=1 and out_ready=0:
  - in_ready=0 and no acceptance occurs.
  - The output holds indefinitely.
- Simultaneous output drain and new acceptance in the same cycle: the new word replaces the old one with no bubble, and out_valid stays 1.
- rst_n deassertion: the first acceptance is possible at the first rising edge after release.

## Test plan
(WIDTH=8, N_IN=4 unless stated.)
1. Fixed select, out_ready=1, chan_en=4'hF, inv_mask=4'b0101, din={8'h44,8'h33,8'h22,8'h11}:
   - sel=0,1,2,3 on consecutive cycles → dout=8'hEE, 8'h22, 8'hCC, 8'h44.
   - dout_ch=0..3, out_valid=1 every cycle from the 2nd.
2. Backpressure: accept sel=1, then hold out_ready=0 for 5 cycles with din changing → dout=8'h22 stable, in_ready=0, out_valid=1. Raise out_ready → the next word loads the same edge.
3. Scan mode: chan_en=4'b1011, 6 back-to-back transfers → dout_ch sequence 0,1,3,0,1,3. Then chan_en=0 → dout=0, sel_err=1, scan_ptr unchanged.
4. Invalid selection:
   - N_IN=5, SEL_W=3, sel=6 → dout=0, sel_err=1, dout_ch=6.
   - N_IN=4, chan_en[2]=0, sel=2 → dout=0, sel_err=1.
5. Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 with scan_ptr=2 → outputs immediately 0, out_valid=0, in_ready=1. After release, the first scan transfer with chan_en=4'hF gives dout_ch=0.
6. Mode switch: scan to dout_ch=1, switch to fixed with sel=3 for 2 transfers, return to scan → next dout_ch=2.
